// File: rtl/combat_resolver.sv
// Per-frame hit resolution for two fighters: folds per-pixel collision strobes into one
// damage decision per frame and tracks health, KO, hit and ball-consume outputs.
module combat_resolver #(
  parameter int unsigned MAX_HEALTH   = 200,
  parameter int unsigned PUNCH_DMG    = 10,
  parameter int unsigned KICK_DMG     = 15,
  parameter int unsigned BALL_DMG     = 30,
  parameter int unsigned BLOCK_SHIFT  = 2,
  parameter int unsigned HIT_COOLDOWN = 30
) (
  input  logic       pixel_Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       round_start,
  input  logic       collision,
  input  logic       ballcollision,
  input  logic       ballcollision2,
  input  logic       punch,
  input  logic       crouchpunch,
  input  logic       kick,
  input  logic       block,
  input  logic       punch2,
  input  logic       crouchpunch2,
  input  logic       kick2,
  input  logic       block2,
  output logic [9:0] health1,
  output logic [9:0] health2,
  output logic       ko1,
  output logic       ko2,
  output logic       hit1,
  output logic       hit2,
  output logic       ball_consume1,
  output logic       ball_consume2,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIGHT = 2'd1,
    S_KO    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic       ov_q, b1_q, b2_q;
  logic       ov_snap, b1_snap, b2_snap;
  logic       resolve, apply;
  logic       valid_q, cons1_q, cons2_q;
  logic [9:0] dmg1_q, dmg2_q;
  logic [9:0] h1_next, h2_next;
  logic [7:0] cd1_q, cd2_q;

  // A strobe on the frame_start cycle itself belongs to the frame being resolved.
  assign ov_snap = ov_q | collision;
  assign b1_snap = b1_q | ballcollision;
  assign b2_snap = b2_q | ballcollision2;

  assign resolve = frame_start && round_start && (state_q == S_FIGHT);
  assign apply   = valid_q && round_start && (state_q == S_FIGHT);

  function automatic logic [9:0] calc_dmg(input logic ov, input logic atk_kick,
                                          input logic atk_punch, input logic atk_cpunch,
                                          input logic ball, input logic blk,
                                          input logic [7:0] cd);
    logic [9:0] raw;
    raw = '0;
    if (ov && atk_kick)                      raw = 10'(KICK_DMG);
    else if (ov && (atk_punch || atk_cpunch)) raw = 10'(PUNCH_DMG);
    if (ball) raw = raw + 10'(BALL_DMG);
    if (blk)  raw = raw >> BLOCK_SHIFT;
    if (cd != 8'd0) raw = '0;
    return raw;
  endfunction

  assign h1_next = (health1 > dmg1_q) ? health1 - dmg1_q : 10'd0;
  assign h2_next = (health2 > dmg2_q) ? health2 - dmg2_q : 10'd0;

  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) begin
      ov_q <= 1'b0;
      b1_q <= 1'b0;
      b2_q <= 1'b0;
    end else if (frame_start) begin
      ov_q <= 1'b0;
      b1_q <= 1'b0;
      b2_q <= 1'b0;
    end else begin
      ov_q <= ov_q | collision;
      b1_q <= b1_q | ballcollision;
      b2_q <= b2_q | ballcollision2;
    end
  end

  // Stage 1: damage for both victims, registered the cycle after frame_start.
  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      dmg1_q  <= '0;
      dmg2_q  <= '0;
      cons1_q <= 1'b0;
      cons2_q <= 1'b0;
    end else begin
      valid_q <= resolve;
      if (resolve) begin
        dmg1_q  <= calc_dmg(ov_snap, kick2, punch2, crouchpunch2, b2_snap, block, cd1_q);
        dmg2_q  <= calc_dmg(ov_snap, kick, punch, crouchpunch, b1_snap, block2, cd2_q);
        cons1_q <= b1_snap;
        cons2_q <= b2_snap;
      end
    end
  end

  // Stage 2: health, cooldown and pulses; leaving the round reloads everything.
  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) begin
      health1       <= 10'(MAX_HEALTH);
      health2       <= 10'(MAX_HEALTH);
      cd1_q         <= '0;
      cd2_q         <= '0;
      hit1          <= 1'b0;
      hit2          <= 1'b0;
      ball_consume1 <= 1'b0;
      ball_consume2 <= 1'b0;
    end else begin
      hit1          <= 1'b0;
      hit2          <= 1'b0;
      ball_consume1 <= 1'b0;
      ball_consume2 <= 1'b0;
      if (!round_start || state_q == S_IDLE) begin
        health1 <= 10'(MAX_HEALTH);
        health2 <= 10'(MAX_HEALTH);
        cd1_q   <= '0;
        cd2_q   <= '0;
      end else if (apply) begin
        health1       <= h1_next;
        health2       <= h2_next;
        hit1          <= (dmg1_q != 10'd0);
        hit2          <= (dmg2_q != 10'd0);
        ball_consume1 <= cons1_q;
        ball_consume2 <= cons2_q;
        if (dmg1_q != 10'd0)   cd1_q <= 8'(HIT_COOLDOWN);
        else if (cd1_q != 8'd0) cd1_q <= cd1_q - 8'd1;
        if (dmg2_q != 10'd0)   cd2_q <= 8'(HIT_COOLDOWN);
        else if (cd2_q != 8'd0) cd2_q <= cd2_q - 8'd1;
      end
    end
  end

  always_ff @(posedge pixel_Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_start && round_start) state_d = S_FIGHT;
      S_FIGHT: begin
        if (!round_start) state_d = S_IDLE;
        else if (apply && (h1_next == 10'd0 || h2_next == 10'd0)) state_d = S_KO;
      end
      S_KO:    if (!round_start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Health and state register on the same edge, so KO is visible with the zero health.
  assign ko1       = (state_q == S_KO) && (health1 == 10'd0);
  assign ko2       = (state_q == S_KO) && (health2 == 10'd0);
  assign dbg_state = state_q;

endmodule
